word32_8bits_c: RTL

- Serializer for the 8b/32b packing path: takes 32-bit words on `clk_4f_c` and emits them as four 8-bit bytes, MSB byte first.
- Byte order is bits [31:24], then [23:16], then [15:8], then [7:0], matching the order in which the packer assembles a word.
- A small word FIFO absorbs input bursts. The output runs at 1 byte/cycle, so the sustained rate is 1 word per 4 cycles.
- Sits on the transmit side of the 8b/32b link, upstream of the byte lane.

---
 rtl/word32_8bits_c.sv | 110 +++++++++++
 1 files changed

// File: rtl/word32_8bits_c.sv
// Purpose: serializes 32-bit words into four bytes, MSB byte first, behind a small word FIFO.
// Latency: a word accepted into an empty FIFO with the FSM idle shows byte0 two edges later; bytes follow on consecutive edges.
// Backpressure: ready_out drops when the FIFO is full; a word offered anyway is dropped and overflow_c sticks high until reset.
module word32_8bits_c #(
    parameter int DEPTH = 2
) (
    input  logic        clk_4f_c,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] Data_in,
    output logic        ready_out,
    output logic        valid_out_c,
    output logic [7:0]  Data_out_c,
    output logic        overflow_c
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [31:0]   fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   fifo_count;

    // Only the three trailing bytes are kept; byte0 leaves directly from the FIFO head.
    logic [23:0]   shift_reg;
    logic [1:0]    byte_cnt;
    logic [0:0]    state;

    logic          push;
    logic          pop;
    logic [31:0]   head;

    // Full FIFO refuses a push even when the serializer pops on the same edge.
    assign ready_out = reset && (fifo_count < FULL_CNT);
    assign push      = valid_in && ready_out;
    assign pop       = (state == IDLE) && (fifo_count != '0);
    assign head      = fifo_mem[rd_ptr];

    // Word storage; contents are don't-care until counted, so no reset needed.
    always_ff @(posedge clk_4f_c) begin
        if (push) begin
            fifo_mem[wr_ptr] <= Data_in;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk_4f_c or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow_c <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (valid_in && !ready_out) begin
                overflow_c <= 1'b1;
            end
        end
    end

    // Serializer: pop and emit byte0 from IDLE, then shift out the remaining three bytes.
    always_ff @(posedge clk_4f_c or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            byte_cnt    <= 2'd0;
            shift_reg   <= 24'h0;
            valid_out_c <= 1'b0;
            Data_out_c  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift_reg   <= head[23:0];
                        Data_out_c  <= head[31:24];
                        valid_out_c <= 1'b1;
                        byte_cnt    <= 2'd1;
                        state       <= SEND;
                    end else begin
                        valid_out_c <= 1'b0;
                        Data_out_c  <= 8'h00;
                    end
                end
                default: begin
                    Data_out_c  <= shift_reg[23:16];
                    shift_reg   <= {shift_reg[15:0], 8'h00};
                    valid_out_c <= 1'b1;
                    byte_cnt    <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
